// File: rtl/vertex_transform_stream.sv
// Streams 4-component signed fixed-point vertices through a 4x4 matrix with a
// double-buffered coefficient set, saturating results and buffering whole vertices.
module vertex_transform_stream #(
    parameter int M     = 11,
    parameter int N     = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M+N-1:0]   in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M+N-1:0]   out_data,
    output logic [1:0]       out_comp,
    output logic             out_last,
    output logic             out_sat,
    input  logic             mat_we,
    input  logic [3:0]       mat_addr,
    input  logic [M+N-1:0]   mat_wdata,
    input  logic             mat_commit,
    output logic             commit_pending,
    output logic             err
);
    localparam int W  = M + N;
    localparam int AW = 2 * W + 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic signed [W-1:0]  ONE  = W'(2 ** N);
    localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [W-1:0] shadow [16];
    logic signed [W-1:0] active [16];
    logic signed [W-1:0] shadow_next [16];

    logic [1:0]    cnt;
    logic [CW-1:0] credits;
    logic          accept, take, w_beat, discard, credit_ret, commit_req, apply;

    // Pipeline: products -> accumulators -> shift/saturate -> vertex buffer -> output beat.
    logic                  p_valid, p_first, p_done, a_done, r_valid;
    logic signed [2*W-1:0] prod [4];
    logic signed [AW-1:0]  acc [4];
    logic [W-1:0]          res [4];
    logic [3:0]            res_sat;

    logic [W-1:0] vbuf [DEPTH][4];
    logic [3:0]   vbuf_sat [DEPTH];
    logic [PW:0]  wr_ptr, rd_ptr;
    logic [1:0]   rd_comp;
    logic         buf_empty, load;

    function automatic logic [W:0] sat_shift(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] sh;
        sh = a >>> N;
        if (sh > MAXV) return {1'b1, MAXV[W-1:0]};
        if (sh < MINV) return {1'b1, MINV[W-1:0]};
        return {1'b0, sh[W-1:0]};
    endfunction

    assign in_ready   = (cnt != 2'd0) || (credits != '0);
    assign accept     = in_valid && in_ready;
    assign take       = accept && (cnt == 2'd0);
    assign w_beat     = accept && (cnt == 2'd3);
    assign discard    = accept && in_last && (cnt != 2'd3);
    assign credit_ret = out_valid && out_ready && out_last;
    assign commit_req = commit_pending || mat_commit;
    // A commit lands only between vertices so no vertex ever mixes two matrices.
    assign apply      = commit_req && (((cnt == 2'd0) && !accept) || w_beat);

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        shadow_next = shadow;
        if (mat_we) shadow_next[mat_addr] = mat_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= 2'd0;
            credits        <= CW'(DEPTH);
            commit_pending <= 1'b0;
            err            <= 1'b0;
        end else begin
            if (accept) cnt <= (discard || cnt == 2'd3) ? 2'd0 : cnt + 2'd1;
            credits        <= credits - CW'(take) + CW'(credit_ret) + CW'(discard);
            commit_pending <= commit_req && !apply;
            if (discard || (w_beat && !in_last)) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                shadow[i] <= (i % 5 == 0) ? ONE : '0;
                active[i] <= (i % 5 == 0) ? ONE : '0;
            end
        end else begin
            shadow <= shadow_next;
            if (apply) active <= shadow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_done  <= 1'b0;
            a_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            p_valid <= accept;
            p_first <= take;
            p_done  <= w_beat;
            a_done  <= p_valid && p_done;
            r_valid <= a_done;
        end
    end

    // NOTE: datapath and buffer storage carry no reset; the valid flags and pointers above gate them.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (accept) prod[j] <= active[{2'(j), cnt}] * $signed(in_data);
            if (p_valid) acc[j] <= p_first ? AW'(prod[j]) : acc[j] + prod[j];
            {res_sat[j], res[j]} <= sat_shift(acc[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (r_valid) begin
            for (int j = 0; j < 4; j++) vbuf[wr_ptr[PW-1:0]][j] <= res[j];
            vbuf_sat[wr_ptr[PW-1:0]] <= res_sat;
        end
    end

    assign buf_empty = (wr_ptr == rd_ptr);
    assign load      = !buf_empty && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_comp   <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_comp  <= 2'd0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            if (r_valid) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= vbuf[rd_ptr[PW-1:0]][rd_comp];
                out_comp  <= rd_comp;
                out_last  <= (rd_comp == 2'd3);
                out_sat   <= vbuf_sat[rd_ptr[PW-1:0]][rd_comp];
                rd_comp   <= rd_comp + 2'd1;
                if (rd_comp == 2'd3) rd_ptr <= rd_ptr + (PW+1)'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vertex_transform_stream.sv
// Directed self-checking bench for vertex_transform_stream (M=11, N=7, DEPTH=4).
module tb_vertex_transform_stream;
    localparam int W = 18;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   c;
        logic         l;
        logic         s;
        int           cy;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, in_last;
    logic [W-1:0] in_data;
    logic         out_valid, out_ready, out_last, out_sat;
    logic [W-1:0] out_data;
    logic [1:0]   out_comp;
    logic         mat_we, mat_commit, commit_pending, err;
    logic [3:0]   mat_addr;
    logic [W-1:0] mat_wdata;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_acc_cyc = 0;
    int    rise_cyc = -1;
    logic  prev_v = 1'b0;
    beat_t q[$];
    beat_t b;

    vertex_transform_stream dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_comp(out_comp), .out_last(out_last), .out_sat(out_sat),
        .mat_we(mat_we), .mat_addr(mat_addr), .mat_wdata(mat_wdata),
        .mat_commit(mat_commit), .commit_pending(commit_pending), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: samples mid-cycle, after bench drives settle and before the edge.
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready)
            q.push_back(beat_t'{d: out_data, c: out_comp, l: out_last, s: out_sat, cy: cyc});
        if (out_valid && !prev_v) rise_cyc = cyc;
        prev_v = out_valid;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        mat_we = 1'b0; mat_addr = '0; mat_wdata = '0; mat_commit = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        q.delete();
        rise_cyc = -1;
    endtask

    task automatic send(input int d, input logic l);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; in_data = W'(d); in_last = l;
        for (int i = 0; i < 300 && !ok; i++) begin
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout: beat %0d not accepted within 300 cycles", d);
        end else begin
            last_acc_cyc = cyc;
        end
    endtask

    task automatic write_mat(input int addr, input int val, input logic commit);
        mat_we = 1'b1; mat_addr = 4'(addr); mat_wdata = W'(val); mat_commit = commit;
        step();
        mat_we = 1'b0; mat_commit = 1'b0;
    endtask

    task automatic pulse_commit();
        mat_commit = 1'b1;
        step();
        mat_commit = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string name);
        for (int i = 0; i < 300 && q.size() < n; i++) step();
        checks++;
        if (q.size() < n) begin
            failures++;
            $display("FAIL %s output_timeout: got %0d beats, want %0d", name, q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_comp !== 2'd0 || out_last !== 1'b0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b data=%0d comp=%0d last=%b sat=%b, want all 0",
                     out_valid, out_data, out_comp, out_last, out_sat);
        end
        checks++;
        if (err !== 1'b0 || commit_pending !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags: got err=%b pending=%b in_ready=%b, want 0 0 1", err, commit_pending, in_ready);
        end
    endtask

    task automatic test_basic();
        int e[4] = '{128, 256, -384, 128};
        do_reset();
        send(128, 0); send(256, 0); send(-384, 0); send(128, 1);
        wait_beats(4, "basic");
        checks++;
        if (rise_cyc - last_acc_cyc !== 4) begin
            failures++;
            $display("FAIL basic_latency: got %0d edges, want 4", rise_cyc - last_acc_cyc);
        end
        for (int j = 0; j < 4 && q.size() > 0; j++) begin
            b = q.pop_front(); checks++;
            if (b.d !== W'(e[j]) || b.c !== 2'(j) || b.l !== (j == 3) || b.s !== 1'b0) begin
                failures++;
                $display("FAIL basic comp%0d: got data=%0d comp=%0d last=%b sat=%b, want data=%0d last=%b sat=0",
                         j, $signed(b.d), b.c, b.l, b.s, e[j], j == 3);
            end
        end
    endtask

    task automatic test_commit();
        int e[4] = '{1408, 256, 384, 128};
        do_reset();
        write_mat(3, 1280, 1'b0);
        pulse_commit();
        checks++;
        if (commit_pending !== 1'b0) begin
            failures++;
            $display("FAIL commit_idle_pending: got %b, want 0", commit_pending);
        end
        send(128, 0); send(256, 0); send(384, 0); send(128, 1);
        wait_beats(4, "commit");
        for (int j = 0; j < 4 && q.size() > 0; j++) begin
            b = q.pop_front(); checks++;
            if (b.d !== W'(e[j]) || b.c !== 2'(j) || b.l !== (j == 3) || b.s !== 1'b0) begin
                failures++;
                $display("FAIL commit comp%0d: got data=%0d comp=%0d last=%b sat=%b, want data=%0d sat=0",
                         j, $signed(b.d), b.c, b.l, b.s, e[j]);
            end
        end
    endtask

    task automatic test_saturate();
        int e[4] = '{131071, 0, 0, 0};
        logic [3:0] es = 4'b0001;
        do_reset();
        write_mat(0, 131071, 1'b1);
        send(131071, 0); send(0, 0); send(0, 0); send(0, 1);
        wait_beats(4, "saturate");
        for (int j = 0; j < 4 && q.size() > 0; j++) begin
            b = q.pop_front(); checks++;
            if (b.d !== W'(e[j]) || b.c !== 2'(j) || b.s !== es[j]) begin
                failures++;
                $display("FAIL saturate comp%0d: got data=%0d comp=%0d sat=%b, want data=%0d sat=%b",
                         j, $signed(b.d), b.c, b.s, e[j], es[j]);
            end
        end
    endtask

    task automatic test_floor_negsat();
        int e[4] = '{-2, -131072, 5, 0};
        logic [3:0] es = 4'b0010;
        do_reset();
        write_mat(0, 64, 1'b0);
        write_mat(5, -131072, 1'b1);
        send(-3, 0); send(200, 0); send(5, 0); send(0, 1);
        wait_beats(4, "floor");
        for (int j = 0; j < 4 && q.size() > 0; j++) begin
            b = q.pop_front(); checks++;
            if (b.d !== W'(e[j]) || b.c !== 2'(j) || b.s !== es[j]) begin
                failures++;
                $display("FAIL floor comp%0d: got data=%0d sat=%b, want data=%0d sat=%b",
                         j, $signed(b.d), b.s, e[j], es[j]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int v = 0; v < 4; v++)
            for (int c = 1; c <= 4; c++) send(v * 16 + c, c == 4);
        repeat (8) step();
        in_valid = 1'b1; in_data = W'(99); in_last = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_ready_full: got %b, want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== W'(1) || out_comp !== 2'd0) begin
            failures++;
            $display("FAIL bp_head: got valid=%b data=%0d comp=%0d, want 1 1 0", out_valid, out_data, out_comp);
        end
        repeat (5) step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== W'(1) || out_comp !== 2'd0 || out_last !== 1'b0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: got valid=%b data=%0d comp=%0d last=%b, want 1 1 0 0", out_valid, out_data, out_comp, out_last);
        end
        out_ready = 1'b1;
        send(99, 0); send(100, 0); send(101, 0); send(102, 1);
        wait_beats(20, "backpressure");
        for (int v = 0; v < 5; v++)
            for (int j = 0; j < 4 && q.size() > 0; j++) begin
                int ev;
                ev = (v < 4) ? v * 16 + j + 1 : 99 + j;
                b = q.pop_front(); checks++;
                if (b.d !== W'(ev) || b.c !== 2'(j) || b.l !== (j == 3)) begin
                    failures++;
                    $display("FAIL bp_order v%0d comp%0d: got data=%0d comp=%0d last=%b, want data=%0d",
                             v, j, $signed(b.d), b.c, b.l, ev);
                end
            end
    endtask

    task automatic test_commit_mid();
        int e[8] = '{10, 20, 30, 128, 20, 20, 30, 128};
        do_reset();
        write_mat(0, 256, 1'b0);
        send(10, 0); send(20, 0);
        pulse_commit();
        checks++;
        if (commit_pending !== 1'b1) begin
            failures++;
            $display("FAIL mid_pending_set: got %b, want 1", commit_pending);
        end
        pulse_commit();
        send(30, 0);
        checks++;
        if (commit_pending !== 1'b1) begin
            failures++;
            $display("FAIL mid_pending_hold: got %b, want 1", commit_pending);
        end
        send(128, 1);
        checks++;
        if (commit_pending !== 1'b0) begin
            failures++;
            $display("FAIL mid_pending_clear: got %b, want 0", commit_pending);
        end
        send(10, 0); send(20, 0); send(30, 0); send(128, 1);
        wait_beats(8, "commit_mid");
        for (int j = 0; j < 8 && q.size() > 0; j++) begin
            b = q.pop_front(); checks++;
            if (b.d !== W'(e[j]) || b.c !== 2'(j % 4)) begin
                failures++;
                $display("FAIL commit_mid beat%0d: got data=%0d comp=%0d, want data=%0d", j, $signed(b.d), b.c, e[j]);
            end
        end
    endtask

    task automatic test_bad_last();
        int e[4] = '{128, 0, 0, 128};
        int e2[8] = '{1, 2, 3, 4, 7, 8, 9, 10};
        do_reset();
        send(5, 0); send(6, 1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL early_last_err: got %b, want 1", err);
        end
        send(128, 0); send(0, 0); send(0, 0); send(128, 1);
        wait_beats(4, "early_last");
        for (int j = 0; j < 4 && q.size() > 0; j++) begin
            b = q.pop_front(); checks++;
            if (b.d !== W'(e[j]) || b.c !== 2'(j)) begin
                failures++;
                $display("FAIL early_last comp%0d: got data=%0d comp=%0d, want data=%0d", j, $signed(b.d), b.c, e[j]);
            end
        end
        repeat (10) step();
        checks++;
        if (q.size() !== 0) begin
            failures++;
            $display("FAIL early_last_extra: got %0d extra beats, want 0", q.size());
        end
        do_reset();
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL missing_last_err: got %b, want 1", err);
        end
        send(7, 0); send(8, 0); send(9, 0); send(10, 1);
        wait_beats(8, "missing_last");
        for (int j = 0; j < 8 && q.size() > 0; j++) begin
            b = q.pop_front(); checks++;
            if (b.d !== W'(e2[j]) || b.l !== (j % 4 == 3)) begin
                failures++;
                $display("FAIL missing_last beat%0d: got data=%0d last=%b, want data=%0d", j, $signed(b.d), b.l, e2[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int start, first_cy;
        do_reset();
        start = cyc;
        for (int i = 0; i < 12; i++) send(i * 3 - 7, i % 4 == 3);
        checks++;
        if (last_acc_cyc - start !== 12) begin
            failures++;
            $display("FAIL b2b_input_rate: got %0d cycles for 12 beats, want 12", last_acc_cyc - start);
        end
        wait_beats(12, "b2b");
        first_cy = (q.size() > 0) ? q[0].cy : 0;
        for (int i = 0; i < 12 && q.size() > 0; i++) begin
            b = q.pop_front(); checks++;
            if (b.d !== W'(i * 3 - 7) || b.c !== 2'(i % 4) || b.cy !== first_cy + i) begin
                failures++;
                $display("FAIL b2b beat%0d: got data=%0d comp=%0d cycle=%0d, want data=%0d cycle=%0d",
                         i, $signed(b.d), b.c, b.cy, i * 3 - 7, first_cy + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e[4] = '{3, 4, 5, 128};
        do_reset();
        out_ready = 1'b0;
        send(11, 0); send(12, 0); send(13, 0); send(14, 1);
        send(9, 0);
        repeat (6) step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        checks++;
        if (q.size() !== 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_flush: got %0d beats valid=%b, want 0 0", q.size(), out_valid);
        end
        send(3, 0); send(4, 0); send(5, 0); send(128, 1);
        wait_beats(4, "reset_mid");
        for (int j = 0; j < 4 && q.size() > 0; j++) begin
            b = q.pop_front(); checks++;
            if (b.d !== W'(e[j]) || b.c !== 2'(j)) begin
                failures++;
                $display("FAIL reset_mid comp%0d: got data=%0d comp=%0d, want data=%0d", j, $signed(b.d), b.c, e[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_commit();
        test_saturate();
        test_floor_negsat();
        test_backpressure();
        test_commit_mid();
        test_bad_last();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vertex_transform_stream.md
VERTEX_TRANSFORM_STREAM -- requirements
Module: vertex_transform_stream

Interface
REQ-001 SHALL have parameter M, default 11: integer bits of the signed fixed-point format.
REQ-002 SHALL have parameter N, default 7: fraction bits; W = M+N is the data width; 1.0 = 2^N.
REQ-003 SHALL have parameter DEPTH, default 4: output buffer capacity in whole vertices (power of 2, >=2).
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 in_valid / in_ready  in / out  1 / 1  input component handshake.
REQ-007 in_data  in  W  signed component, order x,y,z,w.
REQ-008 in_last  in  1  marks the w component.
REQ-009 out_valid / out_ready  out / in  1 / 1  output component handshake.
REQ-010 out_data  out  W  signed transformed component.
REQ-011 out_comp  out  2  index of the component on out_data (0..3).
REQ-012 out_last  out  1  high with out_comp==3.
REQ-013 out_sat  out  1  the current output component was saturated.
REQ-014 mat_we  in  1  write a shadow matrix entry.
REQ-015 mat_addr  in  4  entry index = row*4+col (row = output component, col = input component).
REQ-016 mat_wdata  in  W  signed matrix coefficient.
REQ-017 mat_commit  in  1  single-cycle pulse requesting that the shadow matrix become the active matrix.
REQ-018 commit_pending  out  1  a commit is requested and not yet applied.
REQ-019 err  out  1  sticky protocol-error flag, cleared only by reset.

Function
REQ-020 A beat SHALL transfer on the rising edge where valid and ready are both high; an input component counter cnt (0..3) SHALL track input position.
REQ-021 in_ready SHALL be high when cnt!=0, or when credits>0; credits = DEPTH minus (vertices buffered + vertices in flight + vertex in progress).
REQ-022 A credit SHALL be taken when a cnt==0 beat is accepted, and returned on the out_last handshake or when a vertex is discarded.
REQ-023 For each accepted beat with column k=cnt, the block SHALL register the four products A[j][k]*in_data (2W bits, j=0..3) and add them into four accumulators of width 2W+2; the accumulators SHALL be cleared at the start of each vertex.
REQ-024 Result r_j SHALL equal the accumulator arithmetically shifted right by N (floor), saturated to [-2^(W-1), 2^(W-1)-1]; sat_j SHALL be set when clamping occurred.
REQ-025 Latency: if the w beat is accepted at edge t, the vertex SHALL be written to the buffer at edge t+3, and with the buffer empty and out_ready high, out_valid SHALL rise after edge t+4 with component 0.
REQ-026 Each buffered vertex SHALL be emitted as 4 beats, out_comp 0..3, in acceptance order; out_sat SHALL equal sat_j of the emitted component.
REQ-027 While out_valid && !out_ready, out_data, out_comp, out_last and out_sat SHALL hold stable.
REQ-028 Throughput: with out_ready held high, the block SHALL sustain one input beat and one output beat per cycle indefinitely.
REQ-029 in_last at cnt<3: err SHALL be set, the partial vertex SHALL be discarded (no output, credit returned), and cnt SHALL return to 0.
REQ-030 in_last low at cnt==3: err SHALL be set and the vertex SHALL be processed normally.
REQ-031 mat_we SHALL write the shadow matrix only; the active matrix SHALL never change mid-vertex.
REQ-032 The pending commit SHALL be applied at the first edge where cnt==0 and no input beat is accepted, or together with a w-beat acceptance; the next vertex SHALL use the new matrix.
REQ-033 A commit pulse while a commit is already pending SHALL be absorbed; mat_we and mat_commit in the same cycle SHALL commit the shadow including that write.

Reset
REQ-034 Reset SHALL clear cnt, credits, buffer, pipeline, commit_pending and err; out_valid=0, out_data=0, out_comp=0, out_last=0, out_sat=0.
REQ-035 Reset SHALL load both the active and shadow matrices with identity (2^N on the diagonal, 0 elsewhere).
REQ-036 Reset mid-vertex or mid-output SHALL discard all partial and buffered data without emitting it.

Verification
REQ-037 After reset, in (128,256,-384,128) -> out (128,256,-384,128), out_comp 0..3, out_last on 4th, first out_valid 4 edges after the w beat.
REQ-038 Write mat_addr 3 = 1280, commit; in (128,256,384,128) -> out (1408,256,384,128), commit_pending cleared.
REQ-039 mat_addr 0 = 131071, commit; in x = 131071, others 0 -> out0 = 131071 with out_sat=1, others 0 with out_sat=0.
REQ-040 out_ready=0, DEPTH vertices streamed -> in_ready low for the next x beat, held output stable; out_ready=1 -> all vertices emitted in order, in_ready returns.
REQ-041 Commit pulsed after the y beat -> that vertex uses the old matrix, the following vertex uses the new one.
REQ-042 in_last on the y beat -> err=1, no output for that vertex, next vertex (128,0,0,128) -> (128,0,0,128).
